reaction_timer_core: RTL



---
 rtl/reaction_timer_core.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/reaction_timer_core.sv
// Reaction tester timing engine: button edge detection, random pre-stimulus delay,
// LED stimulus and a millisecond reaction counter feeding the display driver.
module reaction_timer_core #(
  parameter int TICK_DIV    = 50000,
  parameter int INIT_MS     = 1000,
  parameter int RAND_MIN_MS = 1000,
  parameter int RAND_BITS   = 11,
  parameter int LATE_MS     = 9999
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        startB,
  input  logic        stopB,
  input  logic        clearB,
  output logic        led,
  output logic [2:0]  state,
  output logic [13:0] reaction
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [2:0] {
    S_START = 3'd0,
    S_INIT  = 3'd1,
    S_CD    = 3'd2,
    S_TEST  = 3'd3,
    S_EARLY = 3'd4,
    S_GOOD  = 3'd5,
    S_LATE  = 3'd6,
    S_BAD   = 3'd7
  } state_e;

  logic [2:0]    sync1_q, sync2_q, hist_q;
  logic          start_p, stop_p, clear_p;
  state_e        state_q, state_d;
  logic          led_q, led_d;
  logic [13:0]   react_q, react_d;
  logic [13:0]   dly_q, dly_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic          tick;
  logic [13:0]   rand_dly;

  // Bit order {clear, stop, start}; history resets low so a held button fires once.
  assign {clear_p, stop_p, start_p} = sync2_q & ~hist_q;
  assign tick     = (presc_q == PW'(TICK_DIV - 1));
  assign rand_dly = 14'(RAND_MIN_MS) + 14'(lfsr_q[RAND_BITS-1:0]);
  assign lfsr_d   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  always_comb begin
    state_d = state_q;
    led_d   = led_q;
    react_d = react_q;
    dly_d   = dly_q;
    if (clear_p) begin
      state_d = S_START;
      led_d   = 1'b0;
      react_d = '0;
    end else begin
      case (state_q)
        S_START: if (start_p) begin
          state_d = S_INIT;
          dly_d   = 14'(INIT_MS);
        end
        S_INIT: if (tick) begin
          if (dly_q <= 14'd1) begin
            state_d = S_CD;
            dly_d   = rand_dly;
          end else begin
            dly_d = dly_q - 14'd1;
          end
        end
        S_CD: begin
          led_d = 1'b0;
          if (stop_p) begin
            state_d = S_EARLY;
            react_d = '0;
          end else if (tick) begin
            if (dly_q <= 14'd1) begin
              state_d = S_TEST;
              led_d   = 1'b1;
              react_d = '0;
            end else begin
              dly_d = dly_q - 14'd1;
            end
          end
        end
        S_TEST: begin
          led_d = 1'b1;
          // A stop in the tick cycle wins and freezes the pre-tick value.
          if (stop_p) begin
            state_d = S_GOOD;
            led_d   = 1'b0;
          end else if (tick) begin
            if (react_q + 14'd1 >= 14'(LATE_MS)) begin
              state_d = S_LATE;
              led_d   = 1'b0;
              react_d = 14'(LATE_MS);
            end else begin
              react_d = react_q + 14'd1;
            end
          end
        end
        S_EARLY, S_GOOD, S_LATE: begin
          led_d = 1'b0;
          if (start_p) begin
            state_d = S_INIT;
            dly_d   = 14'(INIT_MS);
          end
        end
        default: begin
          state_d = S_START;
          led_d   = 1'b0;
          react_d = '0;
        end
      endcase
    end
  end

  // Restart the prescaler on every transition so the first tick is a full period away.
  always_comb begin
    if (state_d != state_q || tick) presc_d = '0;
    else                            presc_d = presc_q + PW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      hist_q  <= '0;
      state_q <= S_START;
      led_q   <= 1'b0;
      react_q <= '0;
      dly_q   <= '0;
      presc_q <= '0;
      lfsr_q  <= 16'hACE1;
    end else begin
      sync1_q <= {clearB, stopB, startB};
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
      state_q <= state_d;
      led_q   <= led_d;
      react_q <= react_d;
      dly_q   <= dly_d;
      presc_q <= presc_d;
      lfsr_q  <= lfsr_d;
    end
  end

  assign state    = state_q;
  assign led      = led_q;
  assign reaction = react_q;

endmodule
